// File: rtl/irda_pkg.sv
// Shared types, NEC timing constants and frame packing for the IR transmit path.
package irda_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } irda_tx_state_t;

  localparam int unsigned LEAD_MARK_UNITS  = 16;
  localparam int unsigned LEAD_SPACE_UNITS = 8;
  localparam int unsigned ZERO_SPACE_UNITS = 1;
  localparam int unsigned ONE_SPACE_UNITS  = 3;
  localparam int unsigned STOP_UNITS       = 1;
  localparam int unsigned NEC_BITS         = 32;
  localparam int unsigned NEC_BIT_IDX_W    = 5;

  // Bus write payload: low byte is the NEC address, high byte the command.
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
  } nec_req_t;

  // 32-bit NEC word in transmit order; bit 0 goes out first.
  function automatic logic [NEC_BITS-1:0] nec_frame(input logic [7:0] addr,
                                                     input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/irda_carrier_gen.sv
// Carrier phase counter and registered, modulated emitter drive.
module irda_carrier_gen #(
  parameter int unsigned CARRIER_PERIOD = 1316,
  parameter int unsigned CARRIER_HIGH   = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic txd
);

  localparam int unsigned PH_W = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt_c;

  // restart and enable describe the coming cycle, so txd lines up with the FSM state
  always_comb begin
    phase_nxt_c = phase;
    if (restart) begin
      phase_nxt_c = '0;
    end else if (enable) begin
      phase_nxt_c = (32'(phase) == CARRIER_PERIOD - 1) ? '0 : phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      txd   <= 1'b0;
    end else begin
      phase <= phase_nxt_c;
      txd   <= enable && (32'(phase_nxt_c) < CARRIER_HIGH);
    end
  end

endmodule

// File: rtl/irda_nec_tx.sv
// NEC infrared transmitter: encodes bus writes as carrier-modulated NEC frames,
// one frame in flight plus one buffered, with sticky overflow on dropped writes.
module irda_nec_tx #(
  parameter int unsigned UNIT_CYCLES    = 28125,
  parameter int unsigned CARRIER_PERIOD = 1316,
  parameter int unsigned CARRIER_HIGH   = 439,
  parameter int unsigned GAP_UNITS      = 72
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Write,
  input  logic [15:0] WriteData,
  output logic        Busy,
  output logic        Full,
  output logic        Done,
  output logic        Overflow,
  output logic        IrdaTxd
);

  import irda_pkg::*;

  localparam int unsigned CYC_W     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned MAX_UNITS = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
  localparam int unsigned UCNT_W    = $clog2(MAX_UNITS + 1);
  localparam int unsigned BIT_W     = NEC_BIT_IDX_W;

  irda_tx_state_t       state, state_nxt;
  logic [CYC_W-1:0]     cyc, cyc_nxt;
  logic [UCNT_W-1:0]    ucnt, ucnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_idx_nxt;
  logic [NEC_BITS-1:0]  shift, shift_nxt;
  nec_req_t             hold, hold_nxt;
  logic                 full_nxt, ovf_nxt, busy_nxt, done_nxt;

  logic [UCNT_W-1:0]    dur_m1_c;
  logic                 unit_end_c, state_end_c;
  logic                 mark_nxt_c, restart_c;

  // Length of the current state in units, minus one
  always_comb begin
    dur_m1_c = '0;
    case (state)
      LEAD_MARK:  dur_m1_c = UCNT_W'(LEAD_MARK_UNITS - 1);
      LEAD_SPACE: dur_m1_c = UCNT_W'(LEAD_SPACE_UNITS - 1);
      BIT_MARK:   dur_m1_c = UCNT_W'(ZERO_SPACE_UNITS - 1);
      BIT_SPACE:  dur_m1_c = shift[0] ? UCNT_W'(ONE_SPACE_UNITS - 1)
                                      : UCNT_W'(ZERO_SPACE_UNITS - 1);
      STOP_MARK:  dur_m1_c = UCNT_W'(STOP_UNITS - 1);
      GAP:        dur_m1_c = UCNT_W'(GAP_UNITS - 1);
      default:    dur_m1_c = '0;
    endcase
  end

  assign unit_end_c  = (cyc == CYC_W'(UNIT_CYCLES - 1));
  assign state_end_c = unit_end_c && (ucnt == dur_m1_c);

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc;
    ucnt_nxt    = ucnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    hold_nxt    = hold;
    full_nxt    = Full;
    ovf_nxt     = Overflow;
    done_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    mark_nxt_c  = 1'b0;
    restart_c   = 1'b0;

    if (state != IDLE) begin
      if (unit_end_c) begin
        cyc_nxt  = '0;
        ucnt_nxt = ucnt + UCNT_W'(1);
      end else begin
        cyc_nxt = cyc + CYC_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (Write && !Full) begin
          state_nxt   = LEAD_MARK;
          shift_nxt   = nec_frame(WriteData[7:0], WriteData[15:8]);
          bit_idx_nxt = '0;
        end
      end
      LEAD_MARK:  if (state_end_c) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (state_end_c) state_nxt = BIT_MARK;
      BIT_MARK:   if (state_end_c) state_nxt = BIT_SPACE;
      BIT_SPACE: begin
        if (state_end_c) begin
          shift_nxt   = shift >> 1;
          bit_idx_nxt = bit_idx + BIT_W'(1);
          state_nxt   = (bit_idx == BIT_W'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK: begin
        if (state_end_c) begin
          state_nxt = GAP;
          done_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (state_end_c) begin
          if (Full) begin
            state_nxt   = LEAD_MARK;
            shift_nxt   = nec_frame(hold.addr, hold.cmd);
            bit_idx_nxt = '0;
            full_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      cyc_nxt  = '0;
      ucnt_nxt = '0;
    end

    // Acceptance looks only at the registered Full, so a write that lands on
    // the cycle the buffer drains is still dropped.
    if (Write) begin
      if (Full) begin
        ovf_nxt = 1'b1;
      end else if (state != IDLE) begin
        hold_nxt = nec_req_t'(WriteData);
        full_nxt = 1'b1;
      end
    end

    busy_nxt   = (state_nxt != IDLE);
    mark_nxt_c = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
                 (state_nxt == STOP_MARK);
    restart_c  = mark_nxt_c && (state_nxt != state);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      cyc      <= '0;
      ucnt     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      hold     <= '0;
      Full     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      ucnt     <= ucnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      hold     <= hold_nxt;
      Full     <= full_nxt;
      Overflow <= ovf_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
    end
  end

  irda_carrier_gen #(
    .CARRIER_PERIOD(CARRIER_PERIOD),
    .CARRIER_HIGH  (CARRIER_HIGH)
  ) u_carrier (
    .clk    (Clock),
    .rst_n  (Resetn),
    .restart(restart_c),
    .enable (mark_nxt_c),
    .txd    (IrdaTxd)
  );

endmodule

// File: tb/tb_irda_nec_tx.sv
// Bench for irda_nec_tx: per-cycle waveforms checked against a unit-level NEC model.
module tb_irda_nec_tx;

  localparam int unsigned U  = 4;
  localparam int unsigned CP = 3;
  localparam int unsigned CH = 1;
  localparam int unsigned GU = 2;
  localparam int SLOT = 121 * U + GU * U;  // one frame plus its gap
  localparam int MAXN = 1024;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Write = 1'b0;
  logic [15:0] WriteData = '0;
  logic        Busy, Full, Done, Overflow, IrdaTxd;

  int vectors = 0;
  int miscompares = 0;

  logic [MAXN-1:0] o_txd, o_done, o_busy, o_full, o_ovf;
  logic [MAXN-1:0] e_txd, e_done, e_busy;
  int              e_len;
  int              wr_at[$];
  logic [15:0]     wr_dat[$];

  irda_nec_tx #(
    .UNIT_CYCLES(U), .CARRIER_PERIOD(CP), .CARRIER_HIGH(CH), .GAP_UNITS(GU)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Write(Write), .WriteData(WriteData),
    .Busy(Busy), .Full(Full), .Done(Done), .Overflow(Overflow), .IrdaTxd(IrdaTxd)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: expected per-cycle waveform built from NEC units.
  task automatic model_clear();
    e_txd = '0; e_done = '0; e_busy = '0; e_len = 0;
  endtask

  task automatic model_mark(input int units);
    for (int i = 0; i < units * int'(U); i++) begin
      e_txd[e_len]  = ((i % int'(CP)) < int'(CH));
      e_busy[e_len] = 1'b1;
      e_len++;
    end
  endtask

  task automatic model_space(input int units);
    for (int i = 0; i < units * int'(U); i++) begin
      e_busy[e_len] = 1'b1;
      e_len++;
    end
  endtask

  task automatic model_frame(input logic [15:0] d);
    logic [31:0] w;
    w = {~d[15:8], d[15:8], ~d[7:0], d[7:0]};
    model_mark(16);
    model_space(8);
    for (int b = 0; b < 32; b++) begin
      model_mark(1);
      model_space(w[b] ? 3 : 1);
    end
    model_mark(1);
    e_done[e_len] = 1'b1;
    model_space(int'(GU));
  endtask

  function automatic int first_diff(input logic [MAXN-1:0] a, input logic [MAXN-1:0] b);
    for (int i = 0; i < MAXN; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  // Index -1 is the write that opens the window; index k is the cycle after it.
  task automatic capture(input int n);
    o_txd = '0; o_done = '0; o_busy = '0; o_full = '0; o_ovf = '0;
    @(negedge Clock);
    for (int k = -1; k < n; k++) begin
      if (k >= 0) begin
        o_txd[k] = IrdaTxd; o_done[k] = Done; o_busy[k] = Busy;
        o_full[k] = Full;   o_ovf[k] = Overflow;
      end
      Write = 1'b0;
      if (wr_at.size() > 0 && wr_at[0] == k) begin
        Write = 1'b1;
        WriteData = wr_dat[0];
        wr_at.delete(0);
        wr_dat.delete(0);
      end
      @(negedge Clock);
    end
    Write = 1'b0;
  endtask

  task automatic apply_reset();
    Write = 1'b0;
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    logic act;
    Resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      Write = i[0];
      WriteData = 16'($urandom);
      vectors++;
      if ({Busy, Full, Done, Overflow, IrdaTxd} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b want 00000", {Busy, Full, Done, Overflow, IrdaTxd});
      end
    end
    Write = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      act = act | Busy | Full | Done | Overflow | IrdaTxd;
    end
    vectors++;
    if (act !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: activity seen %b want 0", act);
    end
  endtask

  task automatic test_single_frame();
    int d;
    model_clear();
    model_frame(16'h0000);
    wr_at = {-1}; wr_dat = {16'h0000};
    capture(SLOT + 1);
    vectors++;
    if (o_txd !== e_txd) begin
      miscompares++; d = first_diff(o_txd, e_txd);
      $display("FAIL single_txd: cycle %0d got %b want %b", d, o_txd[d], e_txd[d]);
    end
    vectors++;
    if (o_done !== e_done) begin
      miscompares++; d = first_diff(o_done, e_done);
      $display("FAIL single_done: cycle %0d got %b want %b", d, o_done[d], e_done[d]);
    end
    vectors++;
    if (o_busy !== e_busy) begin
      miscompares++; d = first_diff(o_busy, e_busy);
      $display("FAIL single_busy: cycle %0d got %b want %b", d, o_busy[d], e_busy[d]);
    end
  endtask

  task automatic test_bit_decode();
    int pos, len, bad;
    logic [31:0] word;
    wr_at = {-1}; wr_dat = {16'h3CA5};
    capture(SLOT + 1);
    pos = 24 * int'(U);
    word = '0;
    bad = 0;
    for (int b = 0; b < 32; b++) begin
      pos += int'(U);
      len = 0;
      while (pos < SLOT && o_txd[pos] == 1'b0) begin
        len++;
        pos++;
      end
      if (len == 3 * int'(U)) word[b] = 1'b1;
      else if (len != int'(U)) bad++;
    end
    vectors++;
    if (word !== 32'hC33C5AA5) begin
      miscompares++;
      $display("FAIL decode_word: got %h want c33c5aa5", word);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL decode_space_len: %0d bad spaces, want 0", bad);
    end
  endtask

  task automatic test_random_frames();
    logic [15:0] d;
    int x;
    for (int it = 0; it < 3; it++) begin
      d = 16'($urandom);
      model_clear();
      model_frame(d);
      wr_at = {-1}; wr_dat = {d};
      capture(SLOT + 1);
      vectors++;
      if ({o_txd, o_done, o_busy} !== {e_txd, e_done, e_busy}) begin
        miscompares++;
        x = first_diff(o_txd, e_txd);
        $display("FAIL random_frame %h: txd cycle %0d got %b want %b; done ok=%b busy ok=%b",
                 d, x, o_txd[x], e_txd[x], o_done === e_done, o_busy === e_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    apply_reset();
    model_clear();
    model_frame(16'h1111);
    model_frame(16'h2222);
    wr_at = {-1, 100, 200}; wr_dat = {16'h1111, 16'h2222, 16'h3333};
    capture(2 * SLOT + 1);
    vectors++;
    if ({o_full[100], o_full[101], o_full[491], o_full[492]} !== 4'b0110) begin
      miscompares++;
      $display("FAIL b2b_full: got %b want 0110",
               {o_full[100], o_full[101], o_full[491], o_full[492]});
    end
    vectors++;
    if ({o_ovf[200], o_ovf[201], o_ovf[2*SLOT]} !== 3'b011) begin
      miscompares++;
      $display("FAIL b2b_overflow: got %b want 011", {o_ovf[200], o_ovf[201], o_ovf[2*SLOT]});
    end
    vectors++;
    if (o_txd !== e_txd) begin
      miscompares++; d = first_diff(o_txd, e_txd);
      $display("FAIL b2b_txd: cycle %0d got %b want %b", d, o_txd[d], e_txd[d]);
    end
    vectors++;
    if (o_busy !== e_busy) begin
      miscompares++; d = first_diff(o_busy, e_busy);
      $display("FAIL b2b_busy: cycle %0d got %b want %b", d, o_busy[d], e_busy[d]);
    end
    vectors++;
    if (o_done !== e_done) begin
      miscompares++; d = first_diff(o_done, e_done);
      $display("FAIL b2b_done: cycle %0d got %b want %b", d, o_done[d], e_done[d]);
    end
  endtask

  task automatic test_simultaneous();
    int d;
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    apply_reset();
    model_clear();
    model_frame(a);
    model_frame(b);
    wr_at = {-1, 50, SLOT - 1}; wr_dat = {a, b, 16'hBEEF};
    capture(2 * SLOT + 1);
    vectors++;
    if ({o_ovf[SLOT-1], o_ovf[SLOT], o_full[SLOT-1], o_full[SLOT]} !== 4'b0110) begin
      miscompares++;
      $display("FAIL simul_flags: ovf/full got %b want 0110",
               {o_ovf[SLOT-1], o_ovf[SLOT], o_full[SLOT-1], o_full[SLOT]});
    end
    vectors++;
    if ({o_txd, o_busy} !== {e_txd, e_busy}) begin
      miscompares++; d = first_diff(o_txd, e_txd);
      $display("FAIL simul_wave: txd cycle %0d got %b want %b, busy ok=%b",
               d, o_txd[d], e_txd[d], o_busy === e_busy);
    end
  endtask

  task automatic test_mid_reset();
    logic act;
    apply_reset();
    wr_at = {-1, 2}; wr_dat = {16'h5A5A, 16'h0F0F};
    capture(6);
    vectors++;
    if ({IrdaTxd, Busy, Full} !== 3'b111) begin
      miscompares++;
      $display("FAIL midreset_pre: txd/busy/full got %b want 111", {IrdaTxd, Busy, Full});
    end
    #1 Resetn = 1'b0;
    #1;
    vectors++;
    if ({IrdaTxd, Busy, Full} !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_async: txd/busy/full got %b want 000", {IrdaTxd, Busy, Full});
    end
    @(negedge Clock);
    Resetn = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      act = act | IrdaTxd | Busy | Full | Done | Overflow;
    end
    vectors++;
    if (act !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: activity %b want 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bit_decode();
    test_random_frames();
    test_back_to_back();
    test_simultaneous();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
